// File: rtl/prefetcher_pkg.sv
// prefetcher_pkg: shared types and constants for the prefetch request generator.
package prefetcher_pkg;
    typedef enum logic [2:0] {IDLE, TRAIN, CONFIRM, LOCKED, DRAIN} state_t;
    typedef enum logic [1:0] {
        OP_INVALIDATE = 2'd0,
        OP_READ       = 2'd1,
        OP_WRITE_REQ  = 2'd2,
        OP_WRITE_RESP = 2'd3
    } q_op_t;
    localparam int PAGE_SHIFT = 12;
endpackage

// File: rtl/stride_tracker.sv
// stride_tracker: demand delta, legal-stride check and match/mismatch against the trained stride.
module stride_tracker #(
    parameter int BA_ADDR_SIZE         = 64,
    parameter int LOG_BLOCK_DATA_BYTES = 6,
    parameter int MAX_STRIDE_BLOCKS    = 16
) (
    input  logic                    req_valid,
    input  logic [BA_ADDR_SIZE-1:0] req_addr,
    input  logic [BA_ADDR_SIZE-1:0] last_addr,
    input  logic [BA_ADDR_SIZE-1:0] stride,
    output logic                    legal,
    output logic                    match,
    output logic                    mismatch,
    output logic [BA_ADDR_SIZE-1:0] new_stride
);
    localparam logic [BA_ADDR_SIZE-1:0] LIMIT =
        BA_ADDR_SIZE'(MAX_STRIDE_BLOCKS) << LOG_BLOCK_DATA_BYTES;
    logic [BA_ADDR_SIZE-1:0] delta, mag;
    always_comb begin
        delta = req_addr - last_addr;
        mag   = delta[BA_ADDR_SIZE-1] ? -delta : delta;
    end
    assign legal      = (delta != '0) && (mag <= LIMIT);
    assign match      = req_valid && (delta == stride);
    assign mismatch   = req_valid && (delta != stride);
    assign new_stride = delta;
endmodule

// File: rtl/prefetch_req_gen.sv
// prefetch_req_gen: trains on a constant demand stride and issues AXI AR prefetches plus queue opcodes.
// Optional 4 KB page guard on issue: PREFETCH_PAGE_GUARD_EN.
module prefetch_req_gen import prefetcher_pkg::*; #(
    parameter int BA_ADDR_SIZE         = 64,
    parameter int LOG_BLOCK_DATA_BYTES = 6,
    parameter int PF_DEPTH             = 4,
    parameter int MAX_STRIDE_BLOCKS    = 16,
    parameter int ID_WIDTH             = 4,
    parameter int PF_AXI_ID            = 0
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    prefetchEn,
    input  logic                    reqValid,
    input  logic [BA_ADDR_SIZE-1:0] reqAddr,
    input  logic                    almostFull,
    output logic                    arValid,
    input  logic                    arReady,
    output logic [BA_ADDR_SIZE-1:0] arAddr,
    output logic [ID_WIDTH-1:0]     arId,
    output logic                    qOpValid,
    output logic [1:0]              qOpcode,
    output logic [BA_ADDR_SIZE-1:0] qAddr,
    output logic                    flushReq,
    output logic                    strideLocked
);
    state_t state_q, state_d;
    logic [BA_ADDR_SIZE-1:0] last_q, last_d, stride_q, stride_d, next_q, next_d;
    logic [BA_ADDR_SIZE-1:0] araddr_q, araddr_d, dstride_q, dstride_d, new_stride;
    logic [3:0] ahead_q, ahead_d;
    logic arvalid_q, arvalid_d, flush_q, flush_d, locked_q, locked_d, dlegal_q, dlegal_d;
    logic legal, match, mismatch, hs, guard_ok, can_issue;

    stride_tracker #(
        .BA_ADDR_SIZE(BA_ADDR_SIZE),
        .LOG_BLOCK_DATA_BYTES(LOG_BLOCK_DATA_BYTES),
        .MAX_STRIDE_BLOCKS(MAX_STRIDE_BLOCKS)
    ) u_tracker (
        .req_valid(reqValid),
        .req_addr(reqAddr),
        .last_addr(last_q),
        .stride(stride_q),
        .legal(legal),
        .match(match),
        .mismatch(mismatch),
        .new_stride(new_stride)
    );

`ifdef PREFETCH_PAGE_GUARD_EN
    assign guard_ok = next_q[BA_ADDR_SIZE-1:PAGE_SHIFT] == last_q[BA_ADDR_SIZE-1:PAGE_SHIFT];
`else
    assign guard_ok = 1'b1;
`endif

    assign hs        = arvalid_q && arReady;
    assign can_issue = !arvalid_q && prefetchEn && !almostFull &&
                       (ahead_q < 4'(PF_DEPTH)) && guard_ok;

    always_comb begin
        state_d   = state_q;
        last_d    = reqValid ? reqAddr : last_q;
        stride_d  = stride_q;
        next_d    = next_q;
        ahead_d   = ahead_q;
        arvalid_d = arvalid_q && !arReady;
        araddr_d  = araddr_q;
        dstride_d = dstride_q;
        dlegal_d  = dlegal_q;
        flush_d   = 1'b0;
        case (state_q)
            IDLE: if (reqValid) state_d = TRAIN;
            TRAIN: if (reqValid && legal) begin
                stride_d = new_stride;
                state_d  = CONFIRM;
            end
            CONFIRM: if (match) begin
                state_d = LOCKED;
                next_d  = reqAddr + stride_q;
                ahead_d = '0;
            end else if (mismatch) begin
                stride_d = new_stride;
                state_d  = legal ? CONFIRM : TRAIN;
            end
            LOCKED: if (mismatch && arvalid_q && !arReady) begin
                state_d   = DRAIN;
                dstride_d = new_stride;
                dlegal_d  = legal;
            end else if (mismatch) begin
                flush_d  = 1'b1;
                stride_d = new_stride;
                state_d  = legal ? CONFIRM : TRAIN;
            end else begin
                if (hs) next_d = next_q + stride_q;
                if (hs && !match) ahead_d = ahead_q + 4'd1;
                else if (match && !hs && ahead_q != '0) ahead_d = ahead_q - 4'd1;
                // demand caught up with the prefetch stream: restart one stride ahead of it
                else if (match && !hs && !arvalid_q) next_d = reqAddr + stride_q;
                if (can_issue) begin
                    arvalid_d = 1'b1;
                    araddr_d  = next_d;
                end
            end
            DRAIN: if (hs) begin
                flush_d  = 1'b1;
                stride_d = dstride_q;
                state_d  = dlegal_q ? CONFIRM : TRAIN;
            end
            default: state_d = IDLE;
        endcase
        locked_d = state_d == LOCKED;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= IDLE;
            last_q    <= '0;
            stride_q  <= '0;
            next_q    <= '0;
            ahead_q   <= '0;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            dstride_q <= '0;
            dlegal_q  <= 1'b0;
            flush_q   <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            stride_q  <= stride_d;
            next_q    <= next_d;
            ahead_q   <= ahead_d;
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
            dstride_q <= dstride_d;
            dlegal_q  <= dlegal_d;
            flush_q   <= flush_d;
            locked_q  <= locked_d;
        end
    end

    assign arValid      = arvalid_q;
    assign arAddr       = araddr_q;
    assign arId         = ID_WIDTH'(PF_AXI_ID);
    assign qOpValid     = hs;
    assign qOpcode      = hs ? OP_WRITE_REQ : OP_INVALIDATE;
    assign qAddr        = hs ? araddr_q : '0;
    assign flushReq     = flush_q;
    assign strideLocked = locked_q;
endmodule

// File: tb/tb_prefetch_req_gen.sv
// tb_prefetch_req_gen: directed self-checking bench for prefetch_req_gen.
module tb_prefetch_req_gen;
    logic        clk = 1'b0, resetN = 1'b0, prefetchEn = 1'b0, reqValid = 1'b0;
    logic        almostFull = 1'b0, arReady = 1'b0;
    logic [63:0] reqAddr = '0;
    logic        arValid, qOpValid, flushReq, strideLocked;
    logic [63:0] arAddr, qAddr;
    logic [3:0]  arId;
    logic [1:0]  qOpcode;
    int tests = 0, fails = 0;

    prefetch_req_gen dut (
        .clk(clk), .resetN(resetN), .prefetchEn(prefetchEn), .reqValid(reqValid),
        .reqAddr(reqAddr), .almostFull(almostFull), .arValid(arValid), .arReady(arReady),
        .arAddr(arAddr), .arId(arId), .qOpValid(qOpValid), .qOpcode(qOpcode),
        .qAddr(qAddr), .flushReq(flushReq), .strideLocked(strideLocked)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetN = 1'b0; reqValid = 1'b0; arReady = 1'b0; almostFull = 1'b0; prefetchEn = 1'b1;
        repeat (2) tick();
        resetN = 1'b1;
        tick();
    endtask

    task automatic demand(input logic [63:0] a);
        reqValid = 1'b1;
        reqAddr  = a;
        tick();
        reqValid = 1'b0;
    endtask

    task automatic lock3(input logic [63:0] a, input logic [63:0] s);
        demand(a);
        demand(a + s);
        demand(a + s + s);
    endtask

    task automatic wait_ar(output int n);
        n = 0;
        while (arValid !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        resetN = 1'b0; arReady = 1'b1;
        #3;
        tests++;
        if ({arValid, arAddr, arId, qOpValid, qOpcode, qAddr, flushReq, strideLocked} !== '0) begin
            fails++;
            $display("FAIL reset_values: arValid=%b arAddr=%h arId=%h qOpValid=%b qOpcode=%0d qAddr=%h flush=%b locked=%b, expected all 0",
                     arValid, arAddr, arId, qOpValid, qOpcode, qAddr, flushReq, strideLocked);
        end
        do_reset();
    endtask

    task automatic test_basic_stream();
        int n;
        logic seen;
        do_reset();
        arReady = 1'b1;
        lock3(64'h1000, 64'h40);
        tests++;
        if (strideLocked !== 1'b1 || arValid !== 1'b0) begin
            fails++;
            $display("FAIL lock_latency: locked=%b arValid=%b, expected 1 0", strideLocked, arValid);
        end
        tick();
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                tick();
                wait_ar(n);
                tests++;
                if (n > 1) begin
                    fails++;
                    $display("FAIL ar_gap_%0d: %0d idle cycles, expected at most 1", k, n);
                end
            end
            tests++;
            if (arValid !== 1'b1 || arAddr !== 64'h10C0 + 64'(k) * 64'h40) begin
                fails++;
                $display("FAIL ar_stream_%0d: arValid=%b arAddr=%h, expected 1 %h", k, arValid, arAddr,
                         64'h10C0 + 64'(k) * 64'h40);
            end
            tests++;
            if (qOpValid !== 1'b1 || qOpcode !== 2'd2 || qAddr !== 64'h10C0 + 64'(k) * 64'h40) begin
                fails++;
                $display("FAIL qop_stream_%0d: qOpValid=%b qOpcode=%0d qAddr=%h, expected 1 2 %h", k,
                         qOpValid, qOpcode, qAddr, 64'h10C0 + 64'(k) * 64'h40);
            end
        end
        tick();
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            seen |= arValid;
            tick();
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL depth_limit: arValid=%b beyond PF_DEPTH, expected 0", seen);
        end
        demand(64'h10C0);
        wait_ar(n);
        tests++;
        if (arValid !== 1'b1 || arAddr !== 64'h11C0) begin
            fails++;
            $display("FAIL resume_after_demand: arValid=%b arAddr=%h, expected 1 11c0", arValid, arAddr);
        end
    endtask

    task automatic test_negative_stride();
        int n;
        do_reset();
        arReady = 1'b1;
        lock3(64'h2000, -64'h40);
        wait_ar(n);
        tests++;
        if (arValid !== 1'b1 || arAddr !== 64'h1F40) begin
            fails++;
            $display("FAIL neg_stride_first: arValid=%b arAddr=%h, expected 1 1f40", arValid, arAddr);
        end
        tick();
        wait_ar(n);
        tests++;
        if (arValid !== 1'b1 || arAddr !== 64'h1F00) begin
            fails++;
            $display("FAIL neg_stride_second: arValid=%b arAddr=%h, expected 1 1f00", arValid, arAddr);
        end
    endtask

    task automatic test_page();
        int n;
        logic seen;
        do_reset();
        arReady = 1'b1;
        lock3(64'h1F00, 64'h40);
        wait_ar(n);
        tests++;
        if (arValid !== 1'b1 || arAddr !== 64'h1FC0) begin
            fails++;
            $display("FAIL page_first: arValid=%b arAddr=%h, expected 1 1fc0", arValid, arAddr);
        end
        tick();
`ifdef PREFETCH_PAGE_GUARD_EN
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            seen |= arValid;
            tick();
        end
        demand(64'h1FC0);
        for (int i = 0; i < 4; i++) begin
            seen |= arValid;
            tick();
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL page_stall: arValid=%b across page, expected 0", seen);
        end
        demand(64'h2000);
        wait_ar(n);
        tests++;
        if (arValid !== 1'b1 || arAddr !== 64'h2040) begin
            fails++;
            $display("FAIL page_resume: arValid=%b arAddr=%h, expected 1 2040", arValid, arAddr);
        end
`else
        seen = 1'b0;
        wait_ar(n);
        tests++;
        if (arValid !== 1'b1 || arAddr !== 64'h2000) begin
            fails++;
            $display("FAIL page_cross: arValid=%b arAddr=%h, expected 1 2000", arValid, arAddr);
        end
        do_reset();
        arReady = 1'b1;
        lock3(64'hFFFF_FFFF_FFFF_FF40, 64'h40);
        wait_ar(n);
        tests++;
        if (arValid !== 1'b1 || arAddr !== 64'h0 || seen !== 1'b0) begin
            fails++;
            $display("FAIL addr_wrap: arValid=%b arAddr=%h, expected 1 0", arValid, arAddr);
        end
`endif
    endtask

    task automatic test_drain();
        int n;
        do_reset();
        lock3(64'h4F00, 64'h40);
        wait_ar(n);
        demand(64'h5000);
        repeat (2) tick();
        tests++;
        if (arValid !== 1'b1 || arAddr !== 64'h4FC0 || flushReq !== 1'b0 || strideLocked !== 1'b0) begin
            fails++;
            $display("FAIL drain_hold: arValid=%b arAddr=%h flush=%b locked=%b, expected 1 4fc0 0 0",
                     arValid, arAddr, flushReq, strideLocked);
        end
        arReady = 1'b1;
        #1;
        tests++;
        if (qOpValid !== 1'b1 || qAddr !== 64'h4FC0 || flushReq !== 1'b0) begin
            fails++;
            $display("FAIL drain_qop: qOpValid=%b qAddr=%h flush=%b, expected 1 4fc0 0", qOpValid, qAddr, flushReq);
        end
        tick();
        tests++;
        if (flushReq !== 1'b1 || arValid !== 1'b0 || qOpValid !== 1'b0) begin
            fails++;
            $display("FAIL drain_flush: flush=%b arValid=%b qOpValid=%b, expected 1 0 0", flushReq, arValid, qOpValid);
        end
        tick();
        tests++;
        if (flushReq !== 1'b0) begin
            fails++;
            $display("FAIL flush_pulse: flush=%b, expected 0", flushReq);
        end
        demand(64'h5080);
        tests++;
        if (strideLocked !== 1'b1) begin
            fails++;
            $display("FAIL drain_to_confirm: locked=%b, expected 1", strideLocked);
        end
        wait_ar(n);
        tests++;
        if (arValid !== 1'b1 || arAddr !== 64'h5100) begin
            fails++;
            $display("FAIL new_stride_ar: arValid=%b arAddr=%h, expected 1 5100", arValid, arAddr);
        end
    endtask

    task automatic test_almost_full();
        int n;
        logic seen;
        do_reset();
        lock3(64'h6000, 64'h40);
        wait_ar(n);
        almostFull = 1'b1;
        repeat (2) tick();
        tests++;
        if (arValid !== 1'b1 || arAddr !== 64'h60C0) begin
            fails++;
            $display("FAIL af_pending_hold: arValid=%b arAddr=%h, expected 1 60c0", arValid, arAddr);
        end
        arReady = 1'b1;
        tick();
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seen |= arValid;
            tick();
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL af_block: arValid=%b while almostFull, expected 0", seen);
        end
        almostFull = 1'b0;
        tick();
        tests++;
        if (arValid !== 1'b1 || arAddr !== 64'h6100) begin
            fails++;
            $display("FAIL af_resume: arValid=%b arAddr=%h, expected 1 6100", arValid, arAddr);
        end
    endtask

    task automatic test_async_reset();
        int n;
        do_reset();
        lock3(64'h7000, 64'h40);
        wait_ar(n);
        tests++;
        if (arValid !== 1'b1) begin
            fails++;
            $display("FAIL rst_setup: arValid=%b, expected 1", arValid);
        end
        arReady = 1'b1;
        resetN  = 1'b0;
        #2;
        tests++;
        if ({arValid, arAddr, arId, qOpValid, qOpcode, qAddr, flushReq, strideLocked} !== '0) begin
            fails++;
            $display("FAIL async_reset: arValid=%b arAddr=%h qOpValid=%b qAddr=%h flush=%b locked=%b, expected all 0",
                     arValid, arAddr, qOpValid, qAddr, flushReq, strideLocked);
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_basic_stream();
        test_negative_stride();
        test_page();
        test_drain();
        test_almost_full();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
